// File: rtl/usb_clk_pkg.sv
// Shared types and default timing constants for the USB PLL reset sequencer.
package usb_clk_pkg;

   // Sequencer states, in the order a clean start walks through them
   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAIL
   } pll_seq_state_t;

   // Defaults for a 27 MHz reference clock
   localparam int DEF_PULSE_CYC   = 32;       // PLL reset pulse width
   localparam int DEF_STABLE_CYC  = 1024;     // lock qualification time
   localparam int DEF_TIMEOUT_CYC = 270000;   // 10 ms lock wait
   localparam int DEF_RETRY_MAX   = 7;        // timeouts before giving up

   // Largest of three cycle counts; sizes the shared state counter
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/usb_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module usb_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Capture the asynchronous level, then give it a cycle to settle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/usb_pll_rst_seq.sv
// Reset sequencer for the 12 MHz USB PLL: pulses the PLL reset, qualifies the
// synchronised lock and releases the USB-domain reset once lock has held.
// Optional feature macro: USB_PLL_LOCK_TIMEOUT_EN enables the lock-wait
// timeout, bounded retries and the FAIL state.
module usb_pll_rst_seq
   import usb_clk_pkg::*;
#(
   parameter int PULSE_CYC   = DEF_PULSE_CYC,
   parameter int STABLE_CYC  = DEF_STABLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int RETRY_MAX   = DEF_RETRY_MAX
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           pll_lock,
   input  logic                           force_relock,
   output logic                           pll_reset,
   output logic                           usb_rst_n,
   output logic                           ready,
   output logic                           fail,
   output logic [$clog2(RETRY_MAX+1)-1:0] retries
);

   localparam int CNT_MAX = max3(PULSE_CYC, STABLE_CYC, TIMEOUT_CYC);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int RET_W   = $clog2(RETRY_MAX+1);

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] PULSE_TERM  = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_TERM = CNT_W'(STABLE_CYC - 1);
`ifdef USB_PLL_LOCK_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [RET_W-1:0] RET_ONE      = RET_W'(1);
   localparam logic [RET_W-1:0] RETRY_LIM    = RET_W'(RETRY_MAX);
`else
   localparam logic [CNT_W-1:0] CNT_SAT      = '1;
`endif

   logic           lock_s;
   pll_seq_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic           pll_reset_q;
   logic           usb_rst_n_q;
   logic           ready_q;
`ifdef USB_PLL_LOCK_TIMEOUT_EN
   logic             fail_q;
   logic [RET_W-1:0] retries_q, retries_d;
`endif

   usb_sync2 u_lock_sync (
      .clk   (clk),
      .rst_n (resetn),
      .d_i   (pll_lock),
      .q_o   (lock_s)
   );

   // Next state, shared counter and retry count; force_relock overrides all
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef USB_PLL_LOCK_TIMEOUT_EN
      retries_d = retries_q;
`endif
      if (force_relock) begin
         // Also restarts the pulse when already in RESET_PLL
         state_d = RESET_PLL;
         cnt_d   = '0;
`ifdef USB_PLL_LOCK_TIMEOUT_EN
         if (state_q == FAIL) retries_d = '0;
`endif
      end else begin
         case (state_q)
            RESET_PLL: begin
               if (cnt_q == PULSE_TERM) state_d = WAIT_LOCK;
               else                     cnt_d   = cnt_q + CNT_ONE;
            end
            WAIT_LOCK: begin
               // Lock is checked first so it wins a tie with the timeout
               if (lock_s) state_d = STABLE;
`ifdef USB_PLL_LOCK_TIMEOUT_EN
               else if (cnt_q == TIMEOUT_TERM) begin
                  retries_d = retries_q + RET_ONE;
                  state_d   = (retries_d == RETRY_LIM) ? FAIL : RESET_PLL;
               end
               else cnt_d = cnt_q + CNT_ONE;
`else
               else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
`endif
            end
            STABLE: begin
               if (!lock_s) state_d = WAIT_LOCK;
               else if (cnt_q == STABLE_TERM) begin
                  state_d = RUN;
`ifdef USB_PLL_LOCK_TIMEOUT_EN
                  retries_d = '0;
`endif
               end
               else cnt_d = cnt_q + CNT_ONE;
            end
            RUN: begin
               if (!lock_s) state_d = RESET_PLL;
            end
            FAIL: begin
               state_d = FAIL;
            end
            default: state_d = RESET_PLL;
         endcase
         if (state_d != state_q) cnt_d = '0;
      end
   end

   // State registers, with outputs decoded from the next state
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= RESET_PLL;
         cnt_q       <= '0;
         pll_reset_q <= 1'b1;
         usb_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
`ifdef USB_PLL_LOCK_TIMEOUT_EN
         fail_q      <= 1'b0;
         retries_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pll_reset_q <= (state_d == RESET_PLL) || (state_d == FAIL);
         usb_rst_n_q <= (state_d == RUN);
         ready_q     <= (state_d == RUN);
`ifdef USB_PLL_LOCK_TIMEOUT_EN
         fail_q      <= (state_d == FAIL);
         retries_q   <= retries_d;
`endif
      end
   end

   assign pll_reset = pll_reset_q;
   assign usb_rst_n = usb_rst_n_q;
   assign ready     = ready_q;
`ifdef USB_PLL_LOCK_TIMEOUT_EN
   assign fail      = fail_q;
   assign retries   = retries_q;
`else
   assign fail      = 1'b0;
   assign retries   = '0;
`endif

endmodule

// File: tb/tb_usb_pll_rst_seq.sv
// Scoreboard bench for usb_pll_rst_seq with short test timings.
// Stimulus queues expected output snapshots tagged with a clock edge index;
// a monitor pops and compares them on the falling edge after that edge.
module tb_usb_pll_rst_seq;

   localparam int PULSE = 4;
   localparam int STAB  = 16;
   localparam int TMO   = 100;
   localparam int RMAX  = 2;

   logic       clk          = 1'b0;
   logic       resetn       = 1'b0;
   logic       pll_lock     = 1'b0;
   logic       force_relock = 1'b0;
   logic       pll_reset;
   logic       usb_rst_n;
   logic       ready;
   logic       fail;
   logic [1:0] retries;

   usb_pll_rst_seq #(
      .PULSE_CYC   (PULSE),
      .STABLE_CYC  (STAB),
      .TIMEOUT_CYC (TMO),
      .RETRY_MAX   (RMAX)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .pll_lock     (pll_lock),
      .force_relock (force_relock),
      .pll_reset    (pll_reset),
      .usb_rst_n    (usb_rst_n),
      .ready        (ready),
      .fail         (fail),
      .retries      (retries)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      string      name;
      int         cyc;
      logic       pr;
      logic       un;
      logic       rdy;
      logic       fl;
      logic [1:0] ret;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   base     = 0;

   // Insert an expectation keeping the queue ordered by edge index
   task automatic push_abs(input string name, input int cyc, input logic pr,
                           input logic un, input logic rdy, input logic fl,
                           input logic [1:0] ret);
      exp_t e;
      int   i;
      e.name = name; e.cyc = cyc; e.pr = pr; e.un = un;
      e.rdy = rdy; e.fl = fl; e.ret = ret;
      i = 0;
      while (i < sb_q.size() && sb_q[i].cyc <= cyc) i++;
      sb_q.insert(i, e);
   endtask

   task automatic expect_at(input string name, input int k, input logic pr,
                            input logic un, input logic rdy, input logic fl,
                            input logic [1:0] ret);
      push_abs(name, base + k, pr, un, rdy, fl, ret);
   endtask

   // Advance to 1 time unit after edge base+k
   task automatic step_to(input int k);
      while (edge_cnt < base + k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Assert reset mid-cycle (outputs must drop at once), release one edge later
   task automatic do_reset(input logic lock_val);
      resetn       = 1'b0;
      pll_lock     = lock_val;
      force_relock = 1'b0;
      push_abs("async_reset", edge_cnt, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      base   = edge_cnt;
   endtask

   // Monitor: compare every expectation that falls due at this edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
            e = sb_q.pop_front();
            n_checks++;
            if (e.cyc != edge_cnt) begin
               n_fail++;
               $display("FAIL %s: checked at edge %0d, required edge %0d",
                        e.name, edge_cnt, e.cyc);
            end else if (pll_reset !== e.pr || usb_rst_n !== e.un ||
                         ready !== e.rdy || fail !== e.fl || retries !== e.ret) begin
               n_fail++;
               $display("FAIL %s @edge %0d: got pll_reset=%b usb_rst_n=%b ready=%b fail=%b retries=%0d, want pll_reset=%b usb_rst_n=%b ready=%b fail=%b retries=%0d",
                        e.name, edge_cnt, pll_reset, usb_rst_n, ready, fail, retries,
                        e.pr, e.un, e.rdy, e.fl, e.ret);
            end else begin
               $display("ok   %s @edge %0d: pll_reset=%b usb_rst_n=%b ready=%b fail=%b retries=%0d",
                        e.name, edge_cnt, pll_reset, usb_rst_n, ready, fail, retries);
            end
         end
      end
   end

   // Stimulus
   initial begin
      @(posedge clk);
      #1;

      // Clean start: lock first sampled at edge 10 after release
      do_reset(1'b0);
      expect_at("start_k0",        0, 1, 0, 0, 0, 0);
      expect_at("pulse_last",      3, 1, 0, 0, 0, 0);
      expect_at("pulse_end",       4, 0, 0, 0, 0, 0);
      expect_at("wait_lock",      11, 0, 0, 0, 0, 0);
      expect_at("pre_release",    27, 0, 0, 0, 0, 0);
      expect_at("release",        28, 0, 1, 1, 0, 0);
      step_to(9);
      pll_lock = 1'b1;
      step_to(30);

      // Glitch at STABLE count 10, then loss in RUN, then force_relock restarts
      do_reset(1'b1);
      expect_at("glitch_no_early", 21, 0, 0, 0, 0, 0);
      expect_at("glitch_pre_rel",  32, 0, 0, 0, 0, 0);
      expect_at("glitch_release",  33, 0, 1, 1, 0, 0);
      expect_at("run_hold",        42, 0, 1, 1, 0, 0);
      expect_at("loss_drop",       43, 1, 0, 0, 0, 0);
      expect_at("loss_pulse_last", 46, 1, 0, 0, 0, 0);
      expect_at("loss_pulse_end",  47, 0, 0, 0, 0, 0);
      expect_at("force_pre",       49, 0, 0, 0, 0, 0);
      expect_at("force_enter",     50, 1, 0, 0, 0, 0);
      expect_at("force_restart",   54, 1, 0, 0, 0, 0);
      expect_at("restart_last",    55, 1, 0, 0, 0, 0);
      expect_at("restart_end",     56, 0, 0, 0, 0, 0);
      step_to(13); pll_lock = 1'b0;
      step_to(14); pll_lock = 1'b1;
      step_to(40); pll_lock = 1'b0;
      step_to(49); force_relock = 1'b1;
      step_to(50); force_relock = 1'b0;
      step_to(51); force_relock = 1'b1;
      step_to(52); force_relock = 1'b0;

`ifdef USB_PLL_LOCK_TIMEOUT_EN
      step_to(58);

      // Two timeouts lead to FAIL; force_relock recovers
      do_reset(1'b0);
      expect_at("to1_pre",     103, 0, 0, 0, 0, 0);
      expect_at("to1_hit",     104, 1, 0, 0, 0, 1);
      expect_at("to1_pulse",   107, 1, 0, 0, 0, 1);
      expect_at("to1_wait",    108, 0, 0, 0, 0, 1);
      expect_at("to2_pre",     207, 0, 0, 0, 0, 1);
      expect_at("to2_fail",    208, 1, 0, 0, 1, 2);
      expect_at("fail_hold",   300, 1, 0, 0, 1, 2);
      expect_at("fail_force",  301, 1, 0, 0, 0, 0);
      step_to(300); force_relock = 1'b1;
      step_to(301); force_relock = 1'b0;
      step_to(303);

      // Lock arrives on the timeout cycle of the second wait
      do_reset(1'b0);
      expect_at("race_to1",    104, 1, 0, 0, 0, 1);
      expect_at("race_stable", 208, 0, 0, 0, 0, 1);
      expect_at("race_pre",    223, 0, 0, 0, 0, 1);
      expect_at("race_run",    224, 0, 1, 1, 0, 0);
      expect_at("run_pre_frc", 230, 0, 1, 1, 0, 0);
      expect_at("run_force",   231, 1, 0, 0, 0, 0);
      step_to(205); pll_lock = 1'b1;
      step_to(230); force_relock = 1'b1;
      step_to(231); force_relock = 1'b0;
      step_to(233);
`else
      // No timeout: lock held low, the block keeps waiting
      expect_at("no_to_mid",   156, 0, 0, 0, 0, 0);
      expect_at("no_to_long", 1056, 0, 0, 0, 0, 0);
      step_to(1058);
`endif

      repeat (3) @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL %s: never checked, required edge %0d, run ended at edge %0d",
                  e.name, e.cyc, edge_cnt);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
